// File: rtl/output_level_pkg.sv
// Shared definitions for the output_level gain meter.
//   log2_frac(m) : fractional part of log2(1 + m/256) in 1/256 units, used to
//                  build the mantissa table of the log2 stage.
//   DB_SCALE     : 20*log10(2)*10/256 scaled by 2^16, maps a Q4.8 log2
//                  difference to tenths of a dB.
//   MAX_TENTHS   : saturation value of the displayed magnitude (99.9 dB).
//   LOG_W        : width of a Q4.8 log2 value.
//   bcd_t        : one BCD display digit.
package output_level_pkg;

  localparam int unsigned DB_SCALE   = 15413;
  localparam int unsigned MAX_TENTHS = 999;
  localparam int          LOG_W      = 12;

  typedef logic [3:0] bcd_t;

  // round(256 * log2(1 + m/256)), clamped to 255. Integer-only so it can be
  // evaluated at elaboration: x holds (1 + m/256) in Q1.30 and each squaring
  // yields one fractional bit of the logarithm. Twenty bits are produced
  // and rounded down to eight.
  function automatic logic [7:0] log2_frac(input logic [7:0] m);
    logic [63:0] x;
    logic [19:0] acc;
    logic [20:0] rnd;
    x   = {55'd0, 1'b1, m} << 22;
    acc = '0;
    for (int i = 19; i >= 0; i--) begin
      x = (x * x) >> 30;
      if (x[31]) begin
        x      = x >> 1;
        acc[i] = 1'b1;
      end
    end
    rnd = {1'b0, acc} + 21'd2048;
    if (rnd[20]) return 8'd255;
    return rnd[19:12];
  endfunction

endpackage

// File: rtl/output_level_log2.sv
// Registered base-2 logarithm of an unsigned magnitude.
//   clk_i  : sample clock
//   rst_i  : synchronous reset, active-high
//   mag_i  : unsigned magnitude
//   log_o  : Q4.8 log2(mag_i), valid one edge later; 0 when mag_i is 0
//   zero_o : 1 when the registered magnitude was zero
module output_level_log2
  import output_level_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      mag_i,
  output logic [LOG_W-1:0] log_o,
  output logic             zero_o
);

  // Constant mantissa table, folded at elaboration.
  logic [7:0] lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    assign lut[g] = log2_frac(8'(g));
  end

  logic [3:0]       pos;
  logic [7:0]       mant;
  logic [LOG_W-1:0] log_d, log_q;
  logic             zero_d, zero_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (mag_i[i]) pos = 4'(i);
    end
    // Shifting left by 8 then right by pos puts the leading one at bit 8, so
    // the low byte is the eight bits below it, zero-padded for small values.
    mant   = 8'(({mag_i, 8'h00}) >> pos);
    log_d  = {pos, lut[mant]};
    zero_d = (mag_i == 16'd0);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values present before the edge, independent of statement order.
    if (rst_i) begin
      log_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      log_q  <= log_d;
      zero_q <= zero_d;
    end
  end

  assign log_o  = log_q;
  assign zero_o = zero_q;

endmodule

// File: rtl/output_level.sv
// Output-stage gain meter: peak |inWave| and |outWave| over WINDOW samples,
// gain 20*log10(out_peak/in_peak) in tenths of a dB, shown as sign + 3 BCD.
//   clk_48  : 48 kHz sample clock, one sample per rising edge
//   reset_n : synchronous reset, active-high despite the name
//   inWave  : signed input-stage sample
//   outWave : signed output-stage sample
//   num2    : BCD tens-of-dB digit
//   num1    : BCD units-of-dB digit
//   num0    : BCD tenths-of-dB digit
//   neg     : 1 when the gain is negative (attenuation)
// Results appear three edges after the edge that closes a window.
module output_level
  import output_level_pkg::*;
#(
  parameter int unsigned WINDOW = 4800
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic signed [15:0] inWave,
  input  logic signed [15:0] outWave,
  output bcd_t               num2,
  output bcd_t               num1,
  output bcd_t               num0,
  output logic               neg
);

  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  // Saturating magnitude: -32768 has no positive twin, so it maps to 32767.
  function automatic logic [14:0] mag15(input logic signed [15:0] s);
    logic [15:0] n;
    if (s == 16'sh8000) return 15'h7fff;
    n = 16'(-s);
    if (s[15]) return n[14:0];
    return s[14:0];
  endfunction

  logic [15:0]      cnt_q, cnt_d;
  logic [14:0]      run_in_q, run_in_d, run_out_q, run_out_d;
  logic [14:0]      hold_in_q, hold_in_d, hold_out_q, hold_out_d;
  logic [14:0]      mag_in, mag_out, peak_in, peak_out;
  logic [LOG_W-1:0] log_in, log_out;
  logic             zero_in, zero_out;
  logic [9:0]       tenths_q, tenths_d;
  logic             neg_r_q, neg_r_d;
  bcd_t             num2_q, num2_d, num1_q, num1_d, num0_q, num0_d;
  logic             neg_q;

  // Window peak tracking; the closing sample is folded into the held peak.
  always_comb begin
    mag_in     = mag15(inWave);
    mag_out    = mag15(outWave);
    peak_in    = (mag_in  > run_in_q)  ? mag_in  : run_in_q;
    peak_out   = (mag_out > run_out_q) ? mag_out : run_out_q;
    cnt_d      = cnt_q + 16'd1;
    run_in_d   = peak_in;
    run_out_d  = peak_out;
    hold_in_d  = hold_in_q;
    hold_out_d = hold_out_q;
    if (cnt_q == LAST) begin
      cnt_d      = '0;
      run_in_d   = '0;
      run_out_d  = '0;
      hold_in_d  = peak_in;
      hold_out_d = peak_out;
    end
  end

  output_level_log2 u_log_in (
    .clk_i  (clk_48),
    .rst_i  (reset_n),
    .mag_i  ({1'b0, hold_in_q}),
    .log_o  (log_in),
    .zero_o (zero_in)
  );

  output_level_log2 u_log_out (
    .clk_i  (clk_48),
    .rst_i  (reset_n),
    .mag_i  ({1'b0, hold_out_q}),
    .log_o  (log_out),
    .zero_o (zero_out)
  );

  // Gain in tenths of a dB from the Q4.8 log difference.
  logic signed [12:0] diff;
  logic [11:0]        abs_d;
  logic [31:0]        scaled;

  always_comb begin
    diff     = $signed({1'b0, log_out}) - $signed({1'b0, log_in});
    abs_d    = diff[12] ? 12'(-diff) : diff[11:0];
    scaled   = ({20'd0, abs_d} * DB_SCALE + 32'd32768) >> 16;
    tenths_d = (scaled > 32'(MAX_TENTHS)) ? 10'(MAX_TENTHS) : scaled[9:0];
    neg_r_d  = diff[12] && (tenths_d != 10'd0);
    // A silent input gives no meaningful ratio; a silent output is full mute.
    if (zero_in) begin
      tenths_d = '0;
      neg_r_d  = 1'b0;
    end else if (zero_out) begin
      tenths_d = 10'(MAX_TENTHS);
      neg_r_d  = 1'b1;
    end
  end

  logic [9:0] rem100;

  always_comb begin
    num2_d = 4'(tenths_q / 10'd100);
    rem100 = tenths_q % 10'd100;
    num1_d = 4'(rem100 / 10'd10);
    num0_d = 4'(rem100 % 10'd10);
  end

  always_ff @(posedge clk_48) begin
    if (reset_n) begin
      cnt_q      <= '0;
      run_in_q   <= '0;
      run_out_q  <= '0;
      hold_in_q  <= '0;
      hold_out_q <= '0;
      tenths_q   <= '0;
      neg_r_q    <= 1'b0;
      num2_q     <= '0;
      num1_q     <= '0;
      num0_q     <= '0;
      neg_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_in_q   <= run_in_d;
      run_out_q  <= run_out_d;
      hold_in_q  <= hold_in_d;
      hold_out_q <= hold_out_d;
      tenths_q   <= tenths_d;
      neg_r_q    <= neg_r_d;
      num2_q     <= num2_d;
      num1_q     <= num1_d;
      num0_q     <= num0_d;
      neg_q      <= neg_r_q;
    end
  end

  assign num2 = num2_q;
  assign num1 = num1_q;
  assign num0 = num0_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_output_level.sv
module tb_output_level;

  localparam int WIN = 48;

  logic               clk_48 = 1'b0;
  logic               reset_n;
  logic signed [15:0] in_wave, out_wave;
  logic [3:0]         num2, num1, num0;
  logic               neg;

  output_level #(.WINDOW(WIN)) dut (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .inWave  (in_wave),
    .outWave (out_wave),
    .num2    (num2),
    .num1    (num1),
    .num0    (num0),
    .neg     (neg)
  );

  always #10 clk_48 = ~clk_48;

  int n_checks = 0;
  int n_fail   = 0;

  // Displayed value as {neg, num2, num1, num0}.
  logic [12:0] shown_exp;

  typedef enum int {M_SINE, M_HALF, M_CONST} mode_e;
  typedef struct {
    string       name;
    mode_e       mode;
    int          in_amp;
    int          out_amp;
    logic [12:0] exp;
  } case_t;

  // Hand-computed results: -6.0, 0.0, +6.0, -20.0, silent in, muted out, -32768.
  case_t c_half    = '{"half_out",  M_HALF,  32767,  0,     13'h1060};
  case_t c_unity   = '{"unity",     M_SINE,  32767,  32767, 13'h0000};
  case_t c_plus6   = '{"plus_6db",  M_SINE,  8192,   16384, 13'h0060};
  case_t c_minus20 = '{"minus_20",  M_SINE,  32767,  3277,  13'h1200};
  case_t c_zero_in = '{"zero_in",   M_SINE,  0,      32767, 13'h0000};
  case_t c_mute    = '{"zero_out",  M_SINE,  32767,  0,     13'h1999};
  case_t c_negmax  = '{"neg_max",   M_CONST, -32768, 32767, 13'h0000};

  // One period of a 1 kHz sine per 48-sample window, peak exactly amp at k=12.
  function automatic logic signed [15:0] sine_val(int amp, int k);
    real r;
    int  v;
    r = real'(amp) * $sin(6.283185307179586 * real'(k) / 48.0);
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic drive(input case_t c, input int k);
    case (c.mode)
      M_SINE: begin
        in_wave  = sine_val(c.in_amp, k);
        out_wave = sine_val(c.out_amp, k);
      end
      M_HALF: begin
        in_wave  = sine_val(c.in_amp, k);
        out_wave = 16'(in_wave / 2);
      end
      default: begin
        in_wave  = 16'(c.in_amp);
        out_wave = 16'(c.out_amp);
      end
    endcase
  endtask

  // Two aligned windows of one case. The display keeps the previous value
  // until edge 3 of the second window, then shows this case's result.
  task automatic run_windows(input case_t c);
    logic [12:0] exp;
    for (int w = 0; w < 2; w++) begin
      for (int t = 1; t <= WIN; t++) begin
        drive(c, t - 1);
        tick();
        exp = (w == 1 && t >= 3) ? c.exp : shown_exp;
        n_checks++;
        if ({neg, num2, num1, num0} !== exp) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed neg=%0b %0d%0d.%0d, expected neg=%0b %0d%0d.%0d",
                   c.name, w * WIN + t, neg, num2, num1, num0,
                   exp[12], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end
    shown_exp = c.exp;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_wave  = 16'($urandom);
      out_wave = 16'($urandom);
      tick();
      n_checks++;
      if ({neg, num2, num1, num0} !== 13'h0000) begin
        n_fail++;
        $display("FAIL reset cycle %0d: observed neg=%0b %0d%0d.%0d, expected 0 000",
                 i, neg, num2, num1, num0);
      end
    end
    reset_n   = 1'b0;
    shown_exp = 13'h0000;
    run_windows(c_half);
  endtask

  task automatic test_back_to_back();
    run_windows(c_half);
    run_windows(c_half);
  endtask

  task automatic test_gain_cases();
    run_windows(c_unity);
    run_windows(c_plus6);
    run_windows(c_minus20);
  endtask

  task automatic test_boundaries();
    run_windows(c_zero_in);
    run_windows(c_mute);
    run_windows(c_negmax);
  endtask

  task automatic test_mid_window_reset();
    run_windows(c_minus20);
    // Loud input with a quiet output that must not survive the reset.
    for (int t = 0; t < 20; t++) begin
      in_wave  = 16'sd32767;
      out_wave = 16'sd100;
      tick();
    end
    n_checks++;
    if ({neg, num2, num1, num0} !== shown_exp) begin
      n_fail++;
      $display("FAIL pre_reset_hold: observed neg=%0b %0d%0d.%0d, expected neg=%0b %0d%0d.%0d",
               neg, num2, num1, num0, shown_exp[12], shown_exp[11:8], shown_exp[7:4], shown_exp[3:0]);
    end
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    n_checks++;
    if ({neg, num2, num1, num0} !== 13'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_clear: observed neg=%0b %0d%0d.%0d, expected 0 000",
               neg, num2, num1, num0);
    end
    shown_exp = 13'h0000;
    run_windows(c_plus6);
  endtask

  initial begin
    reset_n  = 1'b1;
    in_wave  = '0;
    out_wave = '0;
    test_reset();
    test_back_to_back();
    test_gain_cases();
    test_boundaries();
    test_mid_window_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
